// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   REG_ADDR_W / DATA_W / NUM_REGS / WRCNT_W : datapath dimensions
//   REQ_ALU / REQ_MEM                        : requester indices (grant bit positions)
//   addr_decode()                            : valid-gated one-hot of a register address
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned WRCNT_W    = 16;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // r0 is hardwired to zero, so it never shows up as pending.
  function automatic reg_mask_t addr_decode(input logic valid, input reg_addr_t addr);
    reg_mask_t m;
    m = '0;
    if (valid && addr != '0) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load unit) and the arbiter.
//   stall              : freeze, no grants while high
//   reqN_valid/addr/data/ready : per-requester valid/ready handshake
//   rf_we/waddr/wdata  : registered regfile write port
//   pend               : registers with a write requested but not yet on rf_*
//   wr_count           : number of regfile writes issued
// Modports: slave = arbiter side, master = requester/regfile side.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                 stall;
  logic                 req0_valid;
  reg_addr_t            req0_addr;
  data_t                req0_data;
  logic                 req0_ready;
  logic                 req1_valid;
  reg_addr_t            req1_addr;
  data_t                req1_data;
  logic                 req1_ready;
  logic                 rf_we;
  reg_addr_t            rf_waddr;
  data_t                rf_wdata;
  reg_mask_t            pend;
  logic [WRCNT_W-1:0]   wr_count;

  modport slave (
    input  stall,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_we, rf_waddr, rf_wdata, pend, wr_count
  );

  modport master (
    output stall,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_we, rf_waddr, rf_wdata, pend, wr_count
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
//   req        : request bits, index = requester
//   last_grant : index of the requester granted most recently
//   grant      : one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last_grant);
    grant[1] = req[1] & (~req[0] | ~last_grant);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks onto a
// single regfile write port with round-robin arbitration.
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : writeback interface (slave side), see regfile_wb_arbiter_if
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic               last_grant_q, last_grant_d;
  logic [1:0]         req, grant, xfer;
  reg_addr_t          sel_addr;
  data_t              sel_data;
  logic               we_d;
  logic               rf_we_q;
  reg_addr_t          rf_waddr_q;
  data_t              rf_wdata_q;
  logic [WRCNT_W-1:0] wr_count_q;

  assign req = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    xfer         = 2'b00;
    sel_addr     = bus.req0_addr;
    sel_data     = bus.req0_data;
    we_d         = 1'b0;
    last_grant_d = last_grant_q;
    if (!stall_or_rst()) xfer = grant;
    if (xfer[REQ_MEM]) begin
      sel_addr = bus.req1_addr;
      sel_data = bus.req1_data;
    end
    if (xfer[REQ_ALU]) last_grant_d = 1'b0;
    if (xfer[REQ_MEM]) last_grant_d = 1'b1;
    // Writes to r0 complete the handshake but never reach the regfile.
    we_d = (|xfer) && (sel_addr != '0);
  end

  function automatic logic stall_or_rst();
    return bus.stall | rst;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= we_d;
      if (we_d) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
        wr_count_q <= wr_count_q + 1'b1;
      end
    end
  end

  assign bus.req0_ready = xfer[REQ_ALU];
  assign bus.req1_ready = xfer[REQ_MEM];
  // A write registered just before reset is suppressed in the reset cycle.
  assign bus.rf_we      = rf_we_q & ~rst;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.pend       = addr_decode(bus.req0_valid, bus.req0_addr)
                        | addr_decode(bus.req1_valid, bus.req1_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model + write scoreboard
// plus directed scenarios for the corner cases.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model state
  logic        m_last;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [15:0] m_count;
  logic        rdy0_s, rdy1_s;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req0_valid = v;
    bus.req0_addr  = v ? a : 5'($urandom);
    bus.req0_data  = v ? d : $urandom;
  endtask

  task automatic set_req1(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req1_valid = v;
    bus.req1_addr  = v ? a : 5'($urandom);
    bus.req1_data  = v ? d : $urandom;
  endtask

  // One clock: check everything at the falling edge, advance the model,
  // return 1 time unit after the next rising edge.
  task automatic step();
    logic        g0, g1;
    logic [31:0] exp_pend;
    logic [4:0]  a;
    logic [31:0] d;
    wr_t         w;
    @(negedge clk);
    check_eq("rf_we", 32'(bus.rf_we), 32'(m_we & ~rst));
    if (bus.rf_we) begin
      check_eq("sb_avail", 32'(bus.rf_we), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        w = sb_q.pop_front();
        check_eq("sb_waddr", 32'(bus.rf_waddr), 32'(w.addr));
        check_eq("sb_wdata", bus.rf_wdata, w.data);
      end
    end else begin
      check_eq("hold_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      check_eq("hold_wdata", bus.rf_wdata, m_wdata);
    end
    check_eq("wr_count", 32'(bus.wr_count), 32'(m_count));

    exp_pend = '0;
    if (bus.req0_valid && bus.req0_addr != 0) exp_pend[bus.req0_addr] = 1'b1;
    if (bus.req1_valid && bus.req1_addr != 0) exp_pend[bus.req1_addr] = 1'b1;
    check_eq("pend", bus.pend, exp_pend);

    g0 = bus.req0_valid && (!bus.req1_valid || m_last);
    g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
    if (rst || bus.stall) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
    check_eq("req0_ready", 32'(bus.req0_ready), 32'(g0));
    check_eq("req1_ready", 32'(bus.req1_ready), 32'(g1));
    rdy0_s = bus.req0_ready;
    rdy1_s = bus.req1_ready;

    if (rst) begin
      m_we = 0; m_waddr = 0; m_wdata = 0; m_count = 0; m_last = 1;
      sb_q.delete();
    end else begin
      m_we = 0;
      if (g0 || g1) begin
        a = g1 ? bus.req1_addr : bus.req0_addr;
        d = g1 ? bus.req1_data : bus.req0_data;
        m_last = g1;
        if (a != 0) begin
          m_we = 1; m_waddr = a; m_wdata = d; m_count = m_count + 1'b1;
          sb_q.push_back('{addr: a, data: d});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req0(0, 0, 0);
    set_req1(0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  int          base;
  logic [31:0] seq[$];
  logic [4:0]  exp_addr [4];

  initial begin
    m_last = 1; m_we = 0; m_waddr = 0; m_wdata = 0; m_count = 0;
    rdy0_s = 0; rdy1_s = 0;
    bus.stall = 1'b0;
    set_req0(0, 0, 0);
    set_req1(0, 0, 0);
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_we", 32'(bus.rf_we), 0);
    check_eq("rst_waddr", 32'(bus.rf_waddr), 0);
    check_eq("rst_wdata", bus.rf_wdata, 0);
    check_eq("rst_count", 32'(bus.wr_count), 0);

    // Single ALU write
    set_req0(1, 3, 32'h1234_5678);
    step();
    set_req0(0, 0, 0);
    check_eq("single_we", 32'(bus.rf_we), 1);
    check_eq("single_waddr", 32'(bus.rf_waddr), 3);
    check_eq("single_wdata", bus.rf_wdata, 32'h1234_5678);
    check_eq("single_count", 32'(bus.wr_count), 1);
    step();

    // Continuous contention straight after reset: 2,4,2,4
    do_reset();
    exp_addr = '{5'd2, 5'd4, 5'd2, 5'd4};
    set_req0(1, 2, 32'hA0);
    set_req1(1, 4, 32'hB0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rr_waddr", 32'(bus.rf_waddr), 32'(exp_addr[i]));
    end
    set_req0(0, 0, 0);
    set_req1(0, 0, 0);
    step();

    // Load to r0: handshake only, last_grant moves to req1
    base = int'(bus.wr_count);
    set_req1(1, 0, 32'hFFFF_FFFF);
    step();
    set_req1(0, 0, 0);
    check_eq("r0_ready", 32'(rdy1_s), 1);
    check_eq("r0_we", 32'(bus.rf_we), 0);
    check_eq("r0_count", 32'(bus.wr_count), 32'(base));
    set_req0(1, 9, 32'h99);
    set_req1(1, 10, 32'h1010);
    step();
    check_eq("r0_next_winner", 32'(bus.rf_waddr), 9);
    set_req0(0, 0, 0);
    step();
    set_req1(0, 0, 0);
    step();

    // Same register from both under stall
    do_reset();
    set_req0(1, 29, 32'hA);
    set_req1(1, 29, 32'hB);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_pend29", 32'(bus.pend[29]), 1);
      step();
    end
    bus.stall = 1'b0;
    for (int i = 0; i < 8 && (bus.req0_valid || bus.req1_valid || bus.rf_we); i++) begin
      step();
      if (rdy0_s) set_req0(0, 0, 0);
      if (rdy1_s) set_req1(0, 0, 0);
      if (bus.rf_we) seq.push_back(bus.rf_wdata);
    end
    check_eq("dup_nwrites", 32'(seq.size()), 2);
    if (seq.size() == 2) begin
      check_eq("dup_first", seq[0], 32'hA);
      check_eq("dup_second", seq[1], 32'hB);
    end

    // Reset right after a transfer drops the write
    set_req0(1, 7, 32'h77);
    step();
    set_req0(0, 0, 0);
    rst = 1'b1;
    #1;
    check_eq("drop_we", 32'(bus.rf_we), 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("post_rst_we", 32'(bus.rf_we), 0);
    check_eq("post_rst_waddr", 32'(bus.rf_waddr), 0);
    check_eq("post_rst_wdata", bus.rf_wdata, 0);
    check_eq("post_rst_count", 32'(bus.wr_count), 0);
    check_eq("post_rst_pend", bus.pend, 0);

    // Random traffic; requesters hold until accepted
    for (int i = 0; i < 300; i++) begin
      bus.stall = ($urandom_range(0, 4) == 0);
      if (!bus.req0_valid && $urandom_range(0, 1) == 1)
        set_req0(1, 5'($urandom_range(0, 31)), $urandom);
      if (!bus.req1_valid && $urandom_range(0, 1) == 1)
        set_req1(1, 5'($urandom_range(0, 31)), $urandom);
      step();
      if (rdy0_s) set_req0(0, 0, 0);
      if (rdy1_s) set_req1(0, 0, 0);
    end
    bus.stall = 1'b0;
    set_req0(0, 0, 0);
    set_req1(0, 0, 0);
    step();

    // Counter wrap
    do_reset();
    set_req0(1, 1, 32'h5);
    for (int i = 0; i < 65535; i++) step();
    check_eq("count_ffff", 32'(bus.wr_count), 32'hFFFF);
    step();
    check_eq("count_wrap", 32'(bus.wr_count), 0);
    set_req0(0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-002 Port list (clock and reset first; data registered unless stated):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  freeze; no grants while high.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  5  ALU destination register.
- req0_data  in  32  ALU result.
- req0_ready  out  1  ALU request accepted this cycle (combinational).
- req1_valid  in  1  memory/load writeback request.
- req1_addr  in  5  load destination register.
- req1_data  in  32  load result.
- req1_ready  out  1  load request accepted this cycle (combinational).
- rf_we  out  1  regfile write enable.
- rf_waddr  out  5  regfile write address.
- rf_wdata  out  32  regfile write data.
- pend  out  32  bit n high while a write to register n is requested but not yet on the rf_* port.
- wr_count  out  16  number of regfile writes issued.

Function
REQ-003 A transfer on requester k SHALL occur in a cycle where reqk_valid and reqk_ready are both 1.
- Requesters hold valid, addr and data stable until the transfer.
REQ-004 reqk_ready SHALL be 1 only for the single granted requester, and only when stall is 0 and reqk_valid is 1.
- Both ready outputs SHALL never be 1 in the same cycle.
REQ-005 Arbitration SHALL follow these rules:
- Only one requester valid: that requester is granted.
- Both valid: the requester not granted most recently is granted (2-way round-robin).
REQ-006 The arbiter SHALL hold a last_grant register that updates only on a transfer.
REQ-007 A transfer SHALL drive rf_we=1 with the transferred rf_waddr and rf_wdata in the following cycle (latency 1); otherwise rf_we SHALL be 0 that cycle.
REQ-008 A transfer with addr=0 SHALL complete the handshake and update last_grant.
- It SHALL leave rf_we=0 and not increment wr_count, so r0 stays 0.
REQ-009 rf_waddr and rf_wdata SHALL hold their last values while rf_we=0.
REQ-010 pend[n] SHALL be the combinational OR of (req0_valid and req0_addr==n) and (req1_valid and req1_addr==n).
- pend[0] SHALL always be 0.
REQ-011 Both requesters valid with the same non-zero address SHALL produce two writes on consecutive grants, in round-robin order; the later write determines the final register value.
REQ-012 stall=1 SHALL force both ready outputs to 0 and SHALL NOT change last_grant.
- A write already registered SHALL still issue on rf_* the next cycle.
REQ-013 wr_count SHALL increment by 1 on each cycle with rf_we=1 and SHALL wrap from 0xFFFF to 0x0000.
REQ-014 Inputs are undefined while the corresponding valid is 0; the block SHALL NOT use them in that case.

Reset
REQ-015 While rst=1 at posedge clk, the block SHALL set:
- rf_we=0, rf_waddr=0, rf_wdata=0, wr_count=0.
- last_grant=1, so req0 wins the first contention.
REQ-016 ready outputs SHALL be 0 in any cycle where rst=1.
REQ-017 A write registered in the cycle before rst SHALL be dropped: rf_we=0 in the reset cycle.
- Requesters re-present any request still held valid.

Structure
REQ-018 A shared package SHALL hold the following constants:
- REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, WRCNT_W=16.
- Requester indices REQ_ALU=0 and REQ_MEM=1.
REQ-019 The grant logic SHALL be a sub-module rr_arb2.
- Inputs: two request bits and last_grant.
- Outputs: one-hot grant.
- The top level instantiates it once.
REQ-020 pend SHALL be a purely combinational decode; no other state is permitted beyond last_grant, the rf_* registers and wr_count.

Verification
REQ-021 Only req0_valid, addr=3, data=0x12345678 -> req0_ready=1 that cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x12345678, wr_count=1.
REQ-022 Both valid continuously after reset, addrs 2 and 4 -> grant order req0, req1, req0, req1; rf_waddr sequence 2, 4, 2, 4, one per cycle.
REQ-023 req1_valid, addr=0, data=0xFFFFFFFF -> req1_ready=1; next cycle rf_we=0; wr_count unchanged; last_grant=1.
REQ-024 Both valid, addr=29 each, data 0xA and 0xB, stall=1 for 3 cycles then 0 -> no ready during stall, pend[29]=1; then writes 0xA then 0xB to r29.
REQ-025 Transfer at cycle t and rst=1 at t+1 -> rf_we=0 at t+1; all outputs at reset values at t+2.
REQ-026 wr_count preloaded by 65535 writes, then one more write -> wr_count=0x0000.
